// File: rtl/score_sequencer.sv
// Steps through the score memory, holding each note for its duration; outputs pitch/octave plus a gate for the tone generator.
// Latency: addr_a registered, word latched one cycle after its address is presented; gate/beat are combinational from state.
// Backpressure: pause freezes state, counters and address; start is ignored while busy.
module score_sequencer #(
    parameter int BEAT_DIV  = 3125000,
    parameter int GAP_TICKS = 250000,
    parameter int SONG_LEN  = 150
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        loop_en,
    input  logic [11:0] q_a,
    output logic [15:0] addr_a,
    output logic [3:0]  pitch,
    output logic [2:0]  octave,
    output logic        gate,
    output logic        beat,
    output logic        busy,
    output logic        done
);
    localparam int TW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(BEAT_DIV - 1);
    // With no gap the threshold is irrelevant; clamp so it never overflows TW bits.
    localparam logic [TW-1:0] GAP_START = TW'(BEAT_DIV - ((GAP_TICKS > 0) ? GAP_TICKS : 1));
    localparam bit            HAS_GAP   = (GAP_TICKS > 0);
    localparam logic [15:0]   LAST_ADDR = 16'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PLAY    = 2'd2,
        ADVANCE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [4:0]     unit_cnt_q, unit_cnt_d;
    logic [15:0]    addr_q, addr_d;
    logic [3:0]     pitch_q, pitch_d;
    logic [2:0]     octave_q, octave_d;
    logic           done_q, done_d;
    logic           beat_c;
    logic           gap_zone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            unit_cnt_q <= '0;
            addr_q     <= '0;
            pitch_q    <= '0;
            octave_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            unit_cnt_q <= unit_cnt_d;
            addr_q     <= addr_d;
            pitch_q    <= pitch_d;
            octave_q   <= octave_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        unit_cnt_d = unit_cnt_q;
        addr_d     = addr_q;
        pitch_d    = pitch_q;
        octave_d   = octave_q;
        done_d     = 1'b0;
        beat_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!pause) begin
                    pitch_d    = q_a[11:8];
                    octave_d   = q_a[7:5];
                    unit_cnt_d = q_a[4:0];
                    tick_cnt_d = '0;
                    state_d    = (q_a[4:0] != 5'd0) ? PLAY : ADVANCE;
                end
            end
            PLAY: begin
                if (!pause) begin
                    if (tick_cnt_q == TICK_MAX) begin
                        tick_cnt_d = '0;
                        unit_cnt_d = unit_cnt_q - 5'd1;
                        beat_c     = 1'b1;
                        if (unit_cnt_q == 5'd1) begin
                            state_d = ADVANCE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ADVANCE: begin
                if (!pause) begin
                    if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + 16'd1;
                        state_d = FETCH;
                    end else if (loop_en) begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end else begin
                        addr_d  = '0;
                        pitch_d = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Articulation silence: the tail of the final duration unit of each note.
    assign gap_zone = HAS_GAP && (unit_cnt_q == 5'd1) && (tick_cnt_q >= GAP_START);

    assign gate   = (state_q == PLAY) && (pitch_q != 4'd0) && !pause && !gap_zone;
    assign beat   = beat_c;
    assign addr_a = addr_q;
    assign pitch  = pitch_q;
    assign octave = octave_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
endmodule
